// File: rtl/hi_ssp_receiver.sv
// Slave-side SSP receiver: generates the serial bit clock and byte frame for the ARM,
// deserialises ssp_dout MSB-first on ssp_clk falls and queues completed bytes in a small FIFO.
module hi_ssp_receiver #(
    parameter int CLK_HALF   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       enable,
    input  logic       ssp_dout,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam int            TC_INT   = CLK_HALF - 1;
    localparam logic [7:0]    DIV_TC   = TC_INT[7:0];
    localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [7:0]    div;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic       tc;
    logic       fall;
    logic       push;
    logic       pop;
    logic       full;
    logic       accept;
    logic       ovr_set;
    logic [7:0] byte_in;

    // Event decode: a fall is the terminal-count edge while ssp_clk is high.
    always_comb begin
        tc      = (div == DIV_TC);
        fall    = enable && tc && ssp_clk;
        byte_in = {shift[6:0], ssp_dout};
        push    = fall && (bit_cnt == 3'd7);
        pop     = rx_valid && rx_ready;
        full    = (count == FULL_CNT);
        accept  = push && (!full || pop);
        ovr_set = push && full && !pop;
    end

    assign rx_valid = (count != {(PW+1){1'b0}});
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // Serial clock divider, frame generator and input shift register.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            div       <= 8'd0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
        end else if (!enable) begin
            div       <= 8'd0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
        end else if (tc) begin
            div     <= 8'd0;
            ssp_clk <= ~ssp_clk;
            if (!ssp_clk) begin
                ssp_frame <= (bit_cnt == 3'd0);
            end else begin
                shift   <= byte_in;
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else begin
            div <= div + 8'd1;
        end
    end

    // Receive FIFO storage and pointers; occupancy is one bit wider than the pointers.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {(PW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= byte_in;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

endmodule

// File: tb/tb_hi_ssp_receiver.sv
// Directed self-checking bench for hi_ssp_receiver with default parameters.
module tb_hi_ssp_receiver;

    logic       ck_1356meg = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ssp_dout = 1'b0;
    logic       rx_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       ssp_clk;
    logic       ssp_frame;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;

    int n_chk = 0;
    int n_bad = 0;

    hi_ssp_receiver #(.CLK_HALF(2), .FIFO_DEPTH(4)) dut (
        .ck_1356meg (ck_1356meg),
        .reset      (reset),
        .enable     (enable),
        .ssp_dout   (ssp_dout),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck_1356meg);
        #1;
    endtask

    task automatic wait_rise();
        bit   seen;
        logic p;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            p = ssp_clk;
            tick();
            if (!p && ssp_clk) seen = 1'b1;
        end
        check_val("ssp_clk rise seen", {31'd0, seen}, 32'd1);
    endtask

    // ARM side: drive each bit after an ssp_clk rise; the last fall is two cycles after the last rise.
    task automatic send_byte(input logic [7:0] b, input bit pop_at, input bit clr_at);
        for (int i = 7; i >= 0; i--) begin
            wait_rise();
            if (i == 7) check_val("frame at first bit", {31'd0, ssp_frame}, 32'd1);
            if (i == 6) check_val("frame at second bit", {31'd0, ssp_frame}, 32'd0);
            ssp_dout = b[i];
        end
        tick();
        rx_ready    = pop_at;
        clr_overrun = clr_at;
        tick();
        rx_ready    = 1'b0;
        clr_overrun = 1'b0;
        check_val("ssp_clk low after last fall", {31'd0, ssp_clk}, 32'd0);
    endtask

    task automatic pop_expect(input logic [7:0] e);
        check_val("pop valid", {31'd0, rx_valid}, 32'd1);
        check_val("pop data", {24'd0, rx_data}, {24'd0, e});
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        int         fr;
        a5 = 8'hA5;
        fr = 0;

        tick();
        tick();
        check_val("reset ssp_clk", {31'd0, ssp_clk}, 32'd0);
        check_val("reset ssp_frame", {31'd0, ssp_frame}, 32'd0);
        check_val("reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check_val("reset overrun", {31'd0, overrun}, 32'd0);
        check_val("reset rx_data", {24'd0, rx_data}, 32'h0);
        reset = 1'b0;
        tick();

        // Single byte 0xA5 with exact cycle timing.
        enable = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (c == 1) check_val("ssp_clk low cycle1", {31'd0, ssp_clk}, 32'd0);
            if (c == 2) check_val("ssp_clk rise cycle2", {31'd0, ssp_clk}, 32'd1);
            if ((c % 4) == 2) ssp_dout = a5[7 - (c - 2) / 4];
            fr += int'(ssp_frame);
            if (c == 31) check_val("rx_valid before 32", {31'd0, rx_valid}, 32'd0);
        end
        check_val("rx_valid at 32", {31'd0, rx_valid}, 32'd1);
        check_val("rx_data A5", {24'd0, rx_data}, 32'hA5);
        check_val("frame width", fr, 32'd4);
        enable = 1'b0;
        pop_expect(8'hA5);
        check_val("empty after A5", {31'd0, rx_valid}, 32'd0);

        // Overrun on fifth byte with no consumer.
        enable = 1'b1;
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        check_val("no overrun at full", {31'd0, overrun}, 32'd0);
        send_byte(8'h05, 1'b0, 1'b0);
        check_val("overrun after 5th", {31'd0, overrun}, 32'd1);
        enable = 1'b0;
        pop_expect(8'h01);
        pop_expect(8'h02);
        pop_expect(8'h03);
        pop_expect(8'h04);
        check_val("empty after drain", {31'd0, rx_valid}, 32'd0);
        check_val("overrun sticky", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check_val("overrun cleared", {31'd0, overrun}, 32'd0);

        // Full FIFO with pop on the push cycle of 0x77.
        enable = 1'b1;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b0);
        check_val("no overrun with pop", {31'd0, overrun}, 32'd0);
        enable = 1'b0;
        pop_expect(8'h22);
        pop_expect(8'h33);
        pop_expect(8'h44);
        pop_expect(8'h77);
        check_val("empty after 77", {31'd0, rx_valid}, 32'd0);

        // Partial byte discarded when enable drops after 3 bits.
        enable   = 1'b1;
        ssp_dout = 1'b1;
        repeat (13) tick();
        enable = 1'b0;
        tick();
        check_val("no spurious push", {31'd0, rx_valid}, 32'd0);
        check_val("ssp_clk idle", {31'd0, ssp_clk}, 32'd0);
        check_val("frame idle", {31'd0, ssp_frame}, 32'd0);
        enable = 1'b1;
        send_byte(8'h3C, 1'b0, 1'b0);
        pop_expect(8'h3C);
        check_val("empty after 3C", {31'd0, rx_valid}, 32'd0);

        // Clear coinciding with an overrun-causing push: set wins.
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b1);
        check_val("set beats clear", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check_val("clear next cycle", {31'd0, overrun}, 32'd0);
        enable = 1'b0;
        pop_expect(8'h01);
        pop_expect(8'h02);

        // Asynchronous reset mid-byte with two bytes queued.
        enable = 1'b1;
        wait_rise();
        wait_rise();
        check_val("ssp_clk high pre-reset", {31'd0, ssp_clk}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async reset rx_valid", {31'd0, rx_valid}, 32'd0);
        check_val("async reset overrun", {31'd0, overrun}, 32'd0);
        check_val("async reset ssp_clk", {31'd0, ssp_clk}, 32'd0);
        check_val("async reset frame", {31'd0, ssp_frame}, 32'd0);
        check_val("async reset rx_data", {24'd0, rx_data}, 32'h0);
        tick();
        reset = 1'b0;
        send_byte(8'h5A, 1'b0, 1'b0);
        pop_expect(8'h5A);
        check_val("empty after 5A", {31'd0, rx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hi_ssp_receiver.md
HI_SSP_RECEIVER -- requirements
Module: hi_ssp_receiver

Interface
REQ-001 SHALL have parameter CLK_HALF, default 2, meaning ck_1356meg cycles per ssp_clk half-period (legal 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count (power of two, 2..16).
REQ-003 SHALL have port ck_1356meg  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  runs the serial clock and frame generator when high.
REQ-006 SHALL have port ssp_dout  input  1  serial data from the ARM SSP, MSB first.
REQ-007 SHALL have port ssp_clk  output  1  registered serial bit clock to the ARM.
REQ-008 SHALL have port ssp_frame  output  1  registered byte-frame marker to the ARM.
REQ-009 SHALL have port rx_data  output  8  FIFO head byte.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed byte was dropped.
REQ-013 SHALL have port clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-014 SHALL keep a divider counting 0..CLK_HALF-1 while enable=1; at terminal count it toggles ssp_clk and restarts at 0.
REQ-015 SHALL, with the default parameter, give an ssp_clk period of 2*CLK_HALF = 4 cycles and a byte period of 32 cycles.
REQ-016 SHALL take the first ssp_clk rise exactly CLK_HALF cycles after enable is first sampled high.
REQ-017 SHALL keep a 3-bit bit counter (0..7) that starts at 0.
REQ-018 SHALL drive ssp_frame high on the ssp_clk rise when the bit counter = 0, and low on the next ssp_clk rise, so the frame is one full ssp_clk period wide.
REQ-019 SHALL, on each ssp_clk fall (the ck_1356meg edge that drives ssp_clk 1->0), shift ssp_dout into the LSB of an 8-bit shift register and increment the bit counter modulo 8.
REQ-020 SHALL, on the fall where the bit counter = 7, push {shift[6:0], ssp_dout} into the FIFO in that same cycle.
REQ-021 SHALL hold rx_valid=1 whenever the FIFO is non-empty, and drive rx_data from the FIFO head.
REQ-022 SHALL keep rx_data stable while rx_valid=1 and rx_ready=0.
REQ-023 SHALL pop one entry on each cycle where rx_valid=1 and rx_ready=1; rx_ready while empty has no effect.
REQ-024 SHALL, on simultaneous push and pop, perform both and leave the occupancy unchanged; a full FIFO with a pop in the same cycle accepts the push without overrun.
REQ-025 SHALL, on push to a full FIFO with no pop, drop the new byte, leave the contents unchanged, and set overrun.
REQ-026 SHALL clear overrun on clr_overrun=1, except that set wins when set and clear occur in the same cycle.
REQ-027 SHALL, when enable=0, hold ssp_clk=0 and ssp_frame=0, zero the divider, bit counter and shift register, and retain the FIFO contents and overrun.
REQ-028 SHALL discard a partial byte when enable falls mid-byte, and start the next byte at bit counter 0 with a fresh frame.
REQ-029 SHALL advance FIFO read/write pointers modulo FIFO_DEPTH, and keep occupancy 0..FIFO_DEPTH in a counter one bit wider than the pointers.

Reset
REQ-030 SHALL, while reset=1, force ssp_clk=0, ssp_frame=0, rx_valid=0, overrun=0 and rx_data=8'h00, and zero the divider, bit counter, shift register, pointers and occupancy, independent of the clock.
REQ-031 SHALL restart per REQ-016 on the first enabled cycle after reset deassertion; reset mid-byte discards the partial byte and all FIFO contents.

Verification
REQ-032 SHALL cover: reset pulse mid-byte with 2 bytes queued -> rx_valid=0, overrun=0, ssp_clk=0 within the same cycle; the next byte is received intact.
REQ-033 SHALL cover: enable=1, ARM shifts 0xA5 MSB-first on ssp_clk rises -> rx_valid rises 32 cycles after enable (ssp_clk rise at cycle 2, eighth fall at cycle 32), rx_data=0xA5; ssp_frame high for exactly 4 cycles per 32-cycle byte.
REQ-034 SHALL cover: rx_ready=0, bytes 0x01..0x05 sent -> overrun=1 after the fifth byte; pops then return 0x01,0x02,0x03,0x04, and rx_valid=0 afterward.
REQ-035 SHALL cover: FIFO full with rx_ready=1 exactly on the push cycle of 0x77 -> overrun stays 0, and 0x77 is the last entry popped.
REQ-036 SHALL cover: enable dropped after 3 bits, then re-enabled, then 0x3C sent -> no spurious push, next rx_data=0x3C, and ssp_frame aligns with the new first bit.
REQ-037 SHALL cover: clr_overrun=1 on the same cycle as an overrun-causing push -> overrun=1; clr_overrun the following cycle -> overrun=0.
